// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM state encoding, default word width
// and a width helper for the counters.
package spi_pkg;

  localparam int SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

  // Never returns less than 1 so a counter for a range of one value still has a bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// System-side handshake and SPI pins of spi_master, bundled for port connection.
// master: the spi_master view; slave: the view of whatever drives/observes it.
interface spi_master_if import spi_pkg::*; #(
  parameter int DATA_W = SPI_DATA_W
) ();

  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              cs;
  logic              sclk;
  logic              mosi;
  logic              miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, cs, sclk, mosi
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, cs, sclk, mosi
  );

endinterface

// File: rtl/spi_clk_tick.sv
// Half-period timebase: down-counter reloaded with CLK_DIV-1 that emits a one-cycle
// tick every CLK_DIV cycles; clear realigns it to a freshly accepted transaction.
module spi_clk_tick import spi_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int            CW     = clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, MSB first; miso is captured on sclk falling edges.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from internal mosi instead of miso.
module spi_master import spi_pkg::*; #(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 4
) (
  input logic         clk,
  input logic         rst,
  spi_master_if.master bus
);

  localparam int            BW        = clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_FALL = BW'(DATA_W - 1);
  localparam logic [BW-1:0] ALL_FALLS = BW'(DATA_W);

  spi_state_t        state, state_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic              accept;
  logic              tick;
  logic              rx_bit;

  assign accept = (state == ST_IDLE) && bus.start;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign rx_bit = mosi_q;
`else
  assign rx_bit = bus.miso;
`endif

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_q    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      rx_q    <= rx_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          tx_sh_d   = bus.tx_data;
          mosi_d    = bus.tx_data[DATA_W-1];
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      // The low half-period after the last falling edge stays in SHIFT; HOLD follows it.
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d    = 1'b0;
            rx_sh_d   = {rx_sh[DATA_W-2:0], rx_bit};
            bit_cnt_d = bit_cnt + BW'(1);
            if (bit_cnt != LAST_FALL) begin
              tx_sh_d = tx_sh << 1;
              mosi_d  = tx_sh[DATA_W-2];
            end
          end else if (bit_cnt == ALL_FALLS) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cs      = cs_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_q;

endmodule
